// File: rtl/slog_wb_arbiter_if.sv
// Bus bundle for slog_wb_arbiter: per-lane writeback debug inputs and the serialized slog stream.
// Optional drop counter port present only when SLOG_WB_ARBITER_DROP_CNT_EN is defined.
interface slog_wb_arbiter_if #(
    parameter int NUM_LANES = 6,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32
);
    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    logic [NUM_LANES-1:0]        lane_valid_i;
    logic [NUM_LANES*ADDR_W-1:0] lane_addr_i;
    logic [NUM_LANES*DATA_W-1:0] lane_data_i;
    logic                        slog_valid_o;
    logic [ADDR_W-1:0]           slog_addr_o;
    logic [DATA_W-1:0]           slog_data_o;
    logic [LANE_W-1:0]           slog_lane_o;
    logic                        slog_ready_i;
    logic                        overflow_o;
    logic                        clr_overflow_i;
    logic                        busy_o;
`ifdef SLOG_WB_ARBITER_DROP_CNT_EN
    logic [15:0]                 drop_cnt_o;

    modport slave (
        input  lane_valid_i, lane_addr_i, lane_data_i, slog_ready_i, clr_overflow_i,
        output slog_valid_o, slog_addr_o, slog_data_o, slog_lane_o, overflow_o, busy_o, drop_cnt_o
    );
    modport master (
        output lane_valid_i, lane_addr_i, lane_data_i, slog_ready_i, clr_overflow_i,
        input  slog_valid_o, slog_addr_o, slog_data_o, slog_lane_o, overflow_o, busy_o, drop_cnt_o
    );
`else
    modport slave (
        input  lane_valid_i, lane_addr_i, lane_data_i, slog_ready_i, clr_overflow_i,
        output slog_valid_o, slog_addr_o, slog_data_o, slog_lane_o, overflow_o, busy_o
    );
    modport master (
        output lane_valid_i, lane_addr_i, lane_data_i, slog_ready_i, clr_overflow_i,
        input  slog_valid_o, slog_addr_o, slog_data_o, slog_lane_o, overflow_o, busy_o
    );
`endif
endinterface

// File: rtl/slog_wb_arbiter.sv
// Per-lane FIFOs feeding a round-robin arbiter onto one registered valid/ready debug stream.
// Define SLOG_WB_ARBITER_DROP_CNT_EN to add the saturating 16-bit drop counter.
module slog_wb_arbiter #(
    parameter int NUM_LANES = 6,
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    slog_wb_arbiter_if.slave   bus
);
    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int PTR_W  = $clog2(DEPTH) + 1;
    localparam int IDX_W  = PTR_W - 1;
    localparam int ENT_W  = ADDR_W + DATA_W;
    localparam logic [PTR_W-1:0]  PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [LANE_W-1:0] LANE_ONE  = {{(LANE_W-1){1'b0}}, 1'b1};
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(NUM_LANES - 1);
    localparam logic [LANE_W:0]   LANE_CNT  = (LANE_W+1)'(NUM_LANES);

    logic [ENT_W-1:0]     mem_r    [NUM_LANES][DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r [NUM_LANES];
    logic [PTR_W-1:0]     rd_ptr_r [NUM_LANES];
    logic [LANE_W-1:0]    rr_ptr_r;
    logic                 valid_r;
    logic [ADDR_W-1:0]    addr_r;
    logic [DATA_W-1:0]    data_r;
    logic [LANE_W-1:0]    lane_r;
    logic                 overflow_r;

    logic [NUM_LANES-1:0] empty_s, full_s, push_s, pop_s, drop_s;
    logic                 load_s, gnt_found_s, take_s;
    logic [LANE_W-1:0]    gnt_s;
    logic [LANE_W:0]      cand_s;
    logic [ENT_W-1:0]     head_s;

    // FIFO status: pointers carry one extra wrap bit so full and empty are distinguishable
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            empty_s[i] = (wr_ptr_r[i] == rd_ptr_r[i]);
            full_s[i]  = (wr_ptr_r[i][PTR_W-1] != rd_ptr_r[i][PTR_W-1]) &&
                         (wr_ptr_r[i][IDX_W-1:0] == rd_ptr_r[i][IDX_W-1:0]);
        end
    end

    // Round-robin search: first non-empty lane at or after rr_ptr, wrapping modulo NUM_LANES
    always_comb begin
        gnt_found_s = 1'b0;
        gnt_s       = {LANE_W{1'b0}};
        cand_s      = {(LANE_W+1){1'b0}};
        for (int k = 0; k < NUM_LANES; k++) begin
            cand_s = {1'b0, rr_ptr_r} + (LANE_W+1)'(k);
            if (cand_s >= LANE_CNT) begin
                cand_s = cand_s - LANE_CNT;
            end else begin
                cand_s = cand_s;
            end
            if (!gnt_found_s && !empty_s[cand_s[LANE_W-1:0]]) begin
                gnt_found_s = 1'b1;
                gnt_s       = cand_s[LANE_W-1:0];
            end else begin
                gnt_found_s = gnt_found_s;
            end
        end
    end

    assign load_s = !valid_r || bus.slog_ready_i;
    assign take_s = gnt_found_s && load_s;
    assign head_s = mem_r[gnt_s][rd_ptr_r[gnt_s][IDX_W-1:0]];

    // A full lane still accepts its push when the arbiter pops it at the same edge
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            pop_s[i]  = take_s && (gnt_s == LANE_W'(i));
            push_s[i] = bus.lane_valid_i[i] && (!full_s[i] || pop_s[i]);
            drop_s[i] = bus.lane_valid_i[i] && full_s[i] && !pop_s[i];
        end
    end

    // FIFO storage write port (contents need no reset, pointers qualify them)
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (push_s[i]) begin
                mem_r[i][wr_ptr_r[i][IDX_W-1:0]] <= {bus.lane_addr_i[i*ADDR_W +: ADDR_W],
                                                     bus.lane_data_i[i*DATA_W +: DATA_W]};
            end
        end
    end

    // FIFO read/write pointers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                wr_ptr_r[i] <= {PTR_W{1'b0}};
                rd_ptr_r[i] <= {PTR_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (push_s[i]) wr_ptr_r[i] <= wr_ptr_r[i] + PTR_ONE;
                if (pop_s[i])  rd_ptr_r[i] <= rd_ptr_r[i] + PTR_ONE;
            end
        end
    end

    // Output register and round-robin pointer; payload holds while stalled or idle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_r  <= 1'b0;
            addr_r   <= {ADDR_W{1'b0}};
            data_r   <= {DATA_W{1'b0}};
            lane_r   <= {LANE_W{1'b0}};
            rr_ptr_r <= {LANE_W{1'b0}};
        end else if (take_s) begin
            valid_r  <= 1'b1;
            addr_r   <= head_s[ENT_W-1:DATA_W];
            data_r   <= head_s[DATA_W-1:0];
            lane_r   <= gnt_s;
            rr_ptr_r <= (gnt_s == LANE_LAST) ? {LANE_W{1'b0}} : gnt_s + LANE_ONE;
        end else if (load_s) begin
            valid_r  <= 1'b0;
        end
    end

    // Sticky overflow: a new drop outranks a same-cycle clear
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow_r <= 1'b0;
        end else if (|drop_s) begin
            overflow_r <= 1'b1;
        end else if (bus.clr_overflow_i) begin
            overflow_r <= 1'b0;
        end
    end

`ifdef SLOG_WB_ARBITER_DROP_CNT_EN
    function automatic logic [LANE_W:0] count_ones(input logic [NUM_LANES-1:0] vec);
        logic [LANE_W:0] acc;
        acc = {(LANE_W+1){1'b0}};
        for (int i = 0; i < NUM_LANES; i++) begin
            acc = acc + {{LANE_W{1'b0}}, vec[i]};
        end
        return acc;
    endfunction

    logic [15:0] drop_cnt_r;
    logic [16:0] cnt_sum_s;

    assign cnt_sum_s = {1'b0, (bus.clr_overflow_i ? 16'h0000 : drop_cnt_r)} +
                       {{(16-LANE_W){1'b0}}, count_ones(drop_s)};

    // Saturating drop counter; clear restarts from zero with this cycle's drops added
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_cnt_r <= 16'h0000;
        end else begin
            drop_cnt_r <= cnt_sum_s[16] ? 16'hFFFF : cnt_sum_s[15:0];
        end
    end

    assign bus.drop_cnt_o = drop_cnt_r;
`endif

    assign bus.slog_valid_o = valid_r;
    assign bus.slog_addr_o  = addr_r;
    assign bus.slog_data_o  = data_r;
    assign bus.slog_lane_o  = lane_r;
    assign bus.overflow_o   = overflow_r;
    assign bus.busy_o       = !(&empty_s) || valid_r;
endmodule

// File: tb/tb_slog_wb_arbiter.sv
// Directed + randomized bench for slog_wb_arbiter against a queue-based reference model.
module tb_slog_wb_arbiter;
    localparam int NL = 6;
    localparam int DEPTH = 4;
    localparam int AW = 5;
    localparam int DW = 32;
    typedef logic [AW+DW-1:0] ent_t;

    logic clk = 1'b0;
    logic rst, rdy, clr;
    logic [NL-1:0]    lv;
    logic [NL*AW-1:0] la;
    logic [NL*DW-1:0] ld;
    int checks = 0;
    int errors = 0;

    slog_wb_arbiter_if #(.NUM_LANES(NL), .ADDR_W(AW), .DATA_W(DW)) bus_if ();

    assign bus_if.lane_valid_i   = lv;
    assign bus_if.lane_addr_i    = la;
    assign bus_if.lane_data_i    = ld;
    assign bus_if.slog_ready_i   = rdy;
    assign bus_if.clr_overflow_i = clr;

    slog_wb_arbiter #(.NUM_LANES(NL), .DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    // reference model state
    ent_t q[NL][$];
    logic m_valid, m_ovf, m_was_rst;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int m_lane, m_rr, m_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int g, ndrop;
        logic load, take;
        ent_t e;
        m_was_rst = rst;
        if (rst) begin
            for (int i = 0; i < NL; i++) q[i].delete();
            m_valid = 1'b0; m_addr = '0; m_data = '0; m_lane = 0;
            m_rr = 0; m_ovf = 1'b0; m_cnt = 0;
        end else begin
            load = !m_valid || rdy;
            g = -1;
            for (int k = 0; k < NL; k++) begin
                int j;
                j = (m_rr + k) % NL;
                if (g < 0 && q[j].size() > 0) g = j;
            end
            take = load && (g >= 0);
            e = '0;
            if (take) e = q[g].pop_front();
            ndrop = 0;
            for (int i = 0; i < NL; i++) begin
                if (lv[i]) begin
                    if (q[i].size() < DEPTH) q[i].push_back({la[i*AW +: AW], ld[i*DW +: DW]});
                    else ndrop++;
                end
            end
            if (take) begin
                m_valid = 1'b1; m_addr = e[DW +: AW]; m_data = e[DW-1:0];
                m_lane = g; m_rr = (g + 1) % NL;
            end else if (load) begin
                m_valid = 1'b0;
            end
            if (ndrop > 0) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
            m_cnt = (clr ? 0 : m_cnt) + ndrop;
            if (m_cnt > 65535) m_cnt = 65535;
        end
    endtask

    task automatic compare();
        logic busy;
        busy = m_valid;
        for (int i = 0; i < NL; i++) if (q[i].size() > 0) busy = 1'b1;
        check("valid", 64'(bus_if.slog_valid_o), 64'(m_valid));
        if (m_valid || m_was_rst) begin
            check("addr", 64'(bus_if.slog_addr_o), 64'(m_addr));
            check("data", 64'(bus_if.slog_data_o), 64'(m_data));
            check("lane", 64'(bus_if.slog_lane_o), 64'(m_lane));
        end
        check("overflow", 64'(bus_if.overflow_o), 64'(m_ovf));
        check("busy", 64'(bus_if.busy_o), 64'(busy));
`ifdef SLOG_WB_ARBITER_DROP_CNT_EN
        check("drop_cnt", 64'(bus_if.drop_cnt_o), 64'(m_cnt));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic set_lane(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        lv[i] = 1'b1;
        la[i*AW +: AW] = a;
        ld[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        lv = '0; clr = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        lv = '0; la = '0; ld = '0; rdy = 1'b1; clr = 1'b0; rst = 1'b1;
        #2;
        do_reset();
        check("rst_valid", 64'(bus_if.slog_valid_o), 64'd0);
        check("rst_busy", 64'(bus_if.busy_o), 64'd0);

        // single event with 2-cycle latency
        set_lane(2, 5'h0A, 32'hDEADBEEF);
        tick(); lv = '0;
        tick();
        check("single_valid", 64'(bus_if.slog_valid_o), 64'd1);
        check("single_addr", 64'(bus_if.slog_addr_o), 64'h0A);
        check("single_data", 64'(bus_if.slog_data_o), 64'hDEADBEEF);
        check("single_lane", 64'(bus_if.slog_lane_o), 64'd2);
        tick();
        check("single_idle", 64'(bus_if.slog_valid_o), 64'd0);
        check("single_busy", 64'(bus_if.busy_o), 64'd0);

        // burst fairness from rr_ptr=0; lane 1 arrives after rr has passed it
        do_reset();
        set_lane(0, 5'd0, 32'd0); set_lane(3, 5'd3, 32'd3); set_lane(5, 5'd5, 32'd5);
        tick(); lv = '0;
        tick();
        check("burst_c2", 64'(bus_if.slog_lane_o), 64'd0);
        set_lane(1, 5'd1, 32'd1);
        tick(); lv = '0;
        check("burst_c3", 64'(bus_if.slog_lane_o), 64'd3);
        tick();
        check("burst_c4", 64'(bus_if.slog_lane_o), 64'd5);
        tick();
        check("burst_c5", 64'(bus_if.slog_lane_o), 64'd1);
        for (int i = 0; i < 3; i++) tick();

        // backpressure: payload held while stalled
        do_reset();
        rdy = 1'b0;
        set_lane(0, 5'h11, 32'hA0A0_0001); tick();
        set_lane(0, 5'h12, 32'hA0A0_0002); tick(); lv = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", 64'(bus_if.slog_valid_o), 64'd1);
            check("bp_data", 64'(bus_if.slog_data_o), 64'hA0A0_0001);
        end
        rdy = 1'b1;
        tick();
        check("bp_second", 64'(bus_if.slog_data_o), 64'hA0A0_0002);
        for (int i = 0; i < 3; i++) tick();

        // overflow: 6 pushes into a stalled lane, one dropped
        do_reset();
        rdy = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            set_lane(1, 5'(n), 32'(n));
            tick();
        end
        lv = '0;
        check("ovf_flag", 64'(bus_if.overflow_o), 64'd1);
`ifdef SLOG_WB_ARBITER_DROP_CNT_EN
        check("ovf_cnt", 64'(bus_if.drop_cnt_o), 64'd1);
`endif
        check("ovf_head", 64'(bus_if.slog_data_o), 64'd1);
        rdy = 1'b1;
        for (int n = 2; n <= 5; n++) begin
            tick();
            check("ovf_drain", 64'(bus_if.slog_data_o), 64'(n));
        end
        tick();
        check("ovf_empty", 64'(bus_if.slog_valid_o), 64'd0);
        clr = 1'b1; tick(); clr = 1'b0;
        check("ovf_clr", 64'(bus_if.overflow_o), 64'd0);

        // full lane pushed at the same edge it is popped: no drop
        rdy = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            set_lane(1, 5'(n + 8), 32'(n + 100));
            tick();
        end
        rdy = 1'b1;
        set_lane(1, 5'd31, 32'd999);
        tick(); lv = '0;
        check("fullpop_ovf", 64'(bus_if.overflow_o), 64'd0);
        for (int i = 0; i < 7; i++) tick();

        // reset mid-stream discards everything
        rdy = 1'b0;
        set_lane(0, 5'd1, 32'h111); set_lane(2, 5'd2, 32'h222); set_lane(4, 5'd3, 32'h333);
        tick(); lv = '0; tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("mid_valid", 64'(bus_if.slog_valid_o), 64'd0);
        check("mid_data", 64'(bus_if.slog_data_o), 64'd0);
        check("mid_busy", 64'(bus_if.busy_o), 64'd0);
        rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_stale", 64'(bus_if.slog_valid_o), 64'd0);
        end
        set_lane(4, 5'h1F, 32'hCAFE_F00D); tick(); lv = '0; tick();
        check("mid_new", 64'(bus_if.slog_data_o), 64'hCAFE_F00D);

        // randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NL; i++) begin
                lv[i] = ($urandom_range(0, 99) < 30);
                la[i*AW +: AW] = AW'($urandom);
                ld[i*DW +: DW] = $urandom;
            end
            rdy = ($urandom_range(0, 99) < 70);
            clr = ($urandom_range(0, 99) < 5);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        lv = '0; clr = 1'b0; rst = 1'b0; rdy = 1'b1;
        for (int i = 0; i < NL * DEPTH + 4; i++) tick();
        check("final_busy", 64'(bus_if.busy_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
